sha256_core: RTL
================

SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 SHALL have no parameters; all SHA-256 constants are fixed.
REQ-002 SHALL have clk, input, 1, rising-edge clock.
REQ-003 SHALL have rst, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have m_valid, input, 1, message word strobe from the preprocessor.
REQ-005 SHALL have m_word, input, 32, padded-block word; word 0 arrives first and is W0.
REQ-006 SHALL have busy, output, 1, high in ROUND and FINAL.
REQ-007 SHALL have digest_valid, output, 1, one-cycle pulse marking a new digest.
REQ-008 SHALL have digest, output, 256, H0..H7 concatenated; H0 in bits 255:224.
REQ-009 SHALL have err, output, 1, sticky flag set when a word arrives while busy.

Function
REQ-010 SHALL implement states LOAD, ROUND and FINAL, held in a registered state variable.
REQ-011 LOAD SHALL work as follows:
- each m_valid=1 cycle writes m_word into window[load_cnt] and increments the 4-bit load_cnt;
- m_valid=0 cycles hold load_cnt, so gaps between words are allowed.
REQ-012 On the 16th word's edge, the core SHALL:
- clear load_cnt;
- load working registers a..h with the standard initial hash values (6a09e667 ... 5be0cd19);
- set the round counter t to 0;
- enter ROUND.
REQ-013 ROUND SHALL perform exactly one compression round per cycle, for t = 0..63 (64 cycles).
REQ-014 The round input word W_t SHALL be:
- window[t] for t < 16;
- sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] mod 2^32 for t >= 16, computed from the 16-entry circular window;
- each computed word is written back to window[t mod 16].
REQ-015 All additions SHALL be mod 2^32. T1 = h + Sigma1(e) + Ch(e,f,g) + K[t] + W_t and T2 = Sigma0(a) + Maj(a,b,c), per FIPS 180-4.
REQ-016 After the round with t=63, the core SHALL enter FINAL.
REQ-017 FINAL SHALL last one cycle:
- digest <= {a+H0 .. h+H7};
- digest_valid <= 1 for exactly one cycle;
- return to LOAD.
REQ-018 Each 16-word block SHALL be hashed independently from the initial hash values; there is no multi-block chaining.
REQ-019 Latency: digest_valid SHALL be high in the cycle after the 65th rising edge following the edge that sampled word 15.
REQ-020 digest SHALL hold its value until the next FINAL; digest_valid=0 at all other times.
REQ-021 m_valid=1 while busy SHALL cause:
- the word is dropped;
- window and load_cnt are unchanged;
- err is set and held until reset.
REQ-022 A word arriving in the cycle immediately after FINAL (back in LOAD) SHALL be accepted as word 0 of the next block.
REQ-023 busy SHALL be combinationally equal to (state != LOAD).

Reset
REQ-024 While rst=0, the core SHALL hold:
- state=LOAD, load_cnt=0, t=0;
- a..h=0, window=0;
- digest=0, digest_valid=0, err=0.
REQ-025 rst asserted mid-LOAD or mid-ROUND SHALL abort the block; no digest_valid follows the abort.
REQ-026 After reset release, the first accepted word SHALL be word 0 of a new block.

Structure
REQ-027 sha256_pkg SHALL hold:
- the state enum;
- K[0:63];
- H_INIT[0:7];
- functions Ch, Maj, Sigma0, Sigma1, sigma0, sigma1.
REQ-028 The message schedule (window, W_t selection, expansion and write-back) SHALL be a sub-module, sha256_sched, driven by load strobe/index and t.
REQ-029 The round datapath and FSM SHALL reside in sha256_core; no memories are inferred beyond flop arrays.

Verification
REQ-030 "abc" block (61626380, 14x00000000, 00000018), contiguous -> one digest_valid pulse 65 edges after word 15, digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-031 Empty message block (80000000, 14x00000000, 00000000), with random m_valid gaps -> digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, same latency measured from word 15.
REQ-032 m_valid pulsed at round t=10 during an "abc" hash -> err=1 and sticky; the "abc" digest is unchanged.
REQ-033 rst pulsed at round t=30 during a block, then the "abc" block is sent -> no pulse for the aborted block; the correct "abc" digest follows.
REQ-034 Two blocks back-to-back ("abc", then empty block starting the cycle after FINAL) -> two pulses, 81 cycles apart, with correct digests in order.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM state type, round constants, initial hash
// values and the FIPS 180-4 logical functions.
package sha256_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Rotations are written as concatenations so no shift amounts are needed.
    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_sched.sv
// SHA-256 message schedule: 16-entry circular window holding W[t-16..t-1],
// selecting or expanding W_t and writing it back in place.
module sha256_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [3:0]  load_idx,
    input  logic [31:0] load_word,
    input  logic        round_en,
    input  logic [5:0]  t,
    output logic [31:0] w
);

    logic [31:0] window_r [0:15];
    logic [3:0]  idx_t_s;
    logic [3:0]  idx_2_s;
    logic [3:0]  idx_7_s;
    logic [3:0]  idx_15_s;

    // Window slot t mod 16 holds W[t-16]; the other taps wrap modulo 16.
    always_comb begin
        idx_t_s  = t[3:0];
        idx_2_s  = t[3:0] - 4'd2;
        idx_7_s  = t[3:0] - 4'd7;
        idx_15_s = t[3:0] + 4'd1;
        w        = 32'd0;
        if (t < 6'd16) begin
            w = window_r[idx_t_s];
        end else begin
            w = sigma1(window_r[idx_2_s]) + window_r[idx_7_s]
              + sigma0(window_r[idx_15_s]) + window_r[idx_t_s];
        end
    end

    // Window storage: loaded word-by-word in LOAD, overwritten with W_t in ROUND.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                window_r[i] <= 32'd0;
            end
        end else if (load_en) begin
            window_r[load_idx] <= load_word;
        end else if (round_en) begin
            window_r[idx_t_s] <= w;
        end
    end

endmodule

// File: rtl/sha256_core.sv
// Single-block SHA-256 core: collects 16 words, runs 64 rounds (one per cycle)
// and presents H_INIT + working state as the digest for one pulse.
module sha256_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         m_valid,
    input  logic [31:0]  m_word,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest,
    output logic         err
);

    state_t       state_r;
    state_t       state_s;
    logic [3:0]   load_cnt_r;
    logic [5:0]   t_r;
    logic [31:0]  a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
    logic [255:0] digest_r;
    logic         digest_valid_r;
    logic         err_r;
    logic         load_en_s;
    logic         round_en_s;
    logic         last_word_s;
    logic [31:0]  w_s;
    logic [31:0]  t1_s;
    logic [31:0]  t2_s;

    assign busy         = (state_r != LOAD);
    assign digest       = digest_r;
    assign digest_valid = digest_valid_r;
    assign err          = err_r;

    // Words offered while busy are dropped here, so window and counter stay intact.
    assign load_en_s   = m_valid && (state_r == LOAD);
    assign round_en_s  = (state_r == ROUND);
    assign last_word_s = load_en_s && (load_cnt_r == 4'd15);

    sha256_sched u_sched (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en_s),
        .load_idx  (load_cnt_r),
        .load_word (m_word),
        .round_en  (round_en_s),
        .t         (t_r),
        .w         (w_s)
    );

    // Round function terms T1 and T2.
    always_comb begin
        t1_s = h_r + Sigma1(e_r) + Ch(e_r, f_r, g_r) + K[t_r] + w_s;
        t2_s = Sigma0(a_r) + Maj(a_r, b_r, c_r);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (last_word_s) begin
                    state_s = ROUND;
                end else begin
                    state_s = LOAD;
                end
            end
            ROUND: begin
                if (t_r == 6'd63) begin
                    state_s = FINAL;
                end else begin
                    state_s = ROUND;
                end
            end
            FINAL:   state_s = LOAD;
            default: state_s = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Load counter, round counter and working registers a..h.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_r <= 4'd0;
            t_r        <= 6'd0;
            {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r} <= 256'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (last_word_s) begin
                        load_cnt_r <= 4'd0;
                        t_r        <= 6'd0;
                        a_r <= H_INIT[0]; b_r <= H_INIT[1]; c_r <= H_INIT[2]; d_r <= H_INIT[3];
                        e_r <= H_INIT[4]; f_r <= H_INIT[5]; g_r <= H_INIT[6]; h_r <= H_INIT[7];
                    end else if (load_en_s) begin
                        load_cnt_r <= load_cnt_r + 4'd1;
                    end
                end
                ROUND: begin
                    t_r <= t_r + 6'd1;
                    a_r <= t1_s + t2_s;
                    b_r <= a_r;
                    c_r <= b_r;
                    d_r <= c_r;
                    e_r <= d_r + t1_s;
                    f_r <= e_r;
                    g_r <= f_r;
                    h_r <= g_r;
                end
                FINAL: begin
                    t_r <= 6'd0;
                end
                default: begin
                    t_r <= 6'd0;
                end
            endcase
        end
    end

    // Digest output register; no chaining, every block adds onto H_INIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digest_r       <= 256'd0;
            digest_valid_r <= 1'b0;
        end else begin
            digest_valid_r <= (state_r == FINAL);
            if (state_r == FINAL) begin
                digest_r <= {a_r + H_INIT[0], b_r + H_INIT[1], c_r + H_INIT[2], d_r + H_INIT[3],
                             e_r + H_INIT[4], f_r + H_INIT[5], g_r + H_INIT[6], h_r + H_INIT[7]};
            end
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (m_valid && busy) begin
            err_r <= 1'b1;
        end
    end

endmodule
